// File: rtl/vx_sau_sequencer_pkg.sv
// Shared SAU definitions: sequencer states, element/accumulator
// types and cycle-count helpers for the feed and drain phases.
package vx_sau_sequencer_pkg;

  localparam int SAU_DATA_SIZE = 8;
  localparam int SAU_ACC_SIZE  = 32;

  typedef logic [SAU_DATA_SIZE-1:0] sau_elem_t;
  typedef logic [SAU_ACC_SIZE-1:0]  sau_acc_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_CLEAR,
    SEQ_FEED,
    SEQ_DRAIN,
    SEQ_DONE
  } sau_seq_state_t;

  function automatic int sau_feed_cycles(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int sau_drain_cycles(input int n, input int lat);
    return n - 1 + lat;
  endfunction

endpackage

// File: rtl/vx_sau_sequencer_skew.sv
// Diagonal wavefront generator: lane k carries element t-k of
// row k of A and of column k of B, zero outside the matrix.
module VX_sau_skew
  import vx_sau_sequencer_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int TW = 3
) (
  input  logic [N-1:0][N-1:0][DW-1:0] i_a_rows,
  input  logic [N-1:0][N-1:0][DW-1:0] i_b_cols,
  input  logic [TW-1:0]               i_t,
  output logic [N-1:0][DW-1:0]        o_lane_a,
  output logic [N-1:0][DW-1:0]        o_lane_b
);

  always_comb begin
    o_lane_a = '0;
    o_lane_b = '0;
    for (int k = 0; k < N; k++) begin
      for (int d = 0; d < N; d++) begin
        if (int'(i_t) == k + d) begin
          o_lane_a[k] = i_a_rows[k][d];
          o_lane_b[k] = i_b_cols[k][d];
        end
      end
    end
  end

endmodule

// File: rtl/vx_sau_sequencer.sv
// SAU control sequencer: load A/B, clear, feed skewed wavefronts,
// drain the array pipeline, then hand back the captured tile.
module vx_sau_sequencer
  import vx_sau_sequencer_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_SIZE   = 8,
  parameter int ACC_SIZE    = 32,
  parameter int SA_LATENCY  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic ld_valid,
  output logic ld_ready,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] ld_row_a,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] ld_col_b,
  input  logic abort,
  output logic busy,
  output logic sa_clear,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] sa_in_a,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] sa_in_b,
  input  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][ACC_SIZE-1:0] sa_result,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][ACC_SIZE-1:0] rsp_data
);

  localparam int N  = MATRIX_SIZE;
  localparam int BW = $clog2(N);
  localparam int TW = $clog2(2 * N);
  localparam logic [BW-1:0] B_LAST = BW'(N - 1);
  localparam logic [TW-1:0] T_LAST = TW'(sau_feed_cycles(N) - 1);
  localparam logic [TW-1:0] D_LAST =
    TW'(sau_drain_cycles(N, SA_LATENCY) - 1);

  sau_seq_state_t r_state;
  logic [BW-1:0] r_beat;
  logic [TW-1:0] r_t;
  logic [TW-1:0] r_dcnt;
  logic [N-1:0][N-1:0][DATA_SIZE-1:0] r_a_rows;
  logic [N-1:0][N-1:0][DATA_SIZE-1:0] r_b_cols;
  logic r_sa_clear;
  logic [N-1:0][DATA_SIZE-1:0] r_sa_in_a;
  logic [N-1:0][DATA_SIZE-1:0] r_sa_in_b;
  logic r_rsp_valid;
  logic [N-1:0][N-1:0][ACC_SIZE-1:0] r_rsp_data;

  logic w_abort;
  logic w_ld_fire;
  logic [BW-1:0] w_widx;
  logic [TW-1:0] w_t_nxt;
  logic [N-1:0][DATA_SIZE-1:0] w_lane_a;
  logic [N-1:0][DATA_SIZE-1:0] w_lane_b;

  assign ld_ready = (r_state == SEQ_IDLE) || (r_state == SEQ_LOAD);
  assign busy     = (r_state != SEQ_IDLE);
  assign sa_clear  = r_sa_clear;
  assign sa_in_a   = r_sa_in_a;
  assign sa_in_b   = r_sa_in_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  assign w_abort   = abort && (r_state != SEQ_IDLE);
  assign w_ld_fire = reset && ld_valid && ld_ready && !w_abort;
  assign w_widx    = (r_state == SEQ_IDLE) ? '0 : r_beat;
  // Lanes are registered, so look up the wavefront for the next cycle.
  assign w_t_nxt   = (r_state == SEQ_FEED) ? r_t + TW'(1) : '0;

  VX_sau_skew #(
    .N  (N),
    .DW (DATA_SIZE),
    .TW (TW)
  ) u_skew (
    .i_a_rows (r_a_rows),
    .i_b_cols (r_b_cols),
    .i_t      (w_t_nxt),
    .o_lane_a (w_lane_a),
    .o_lane_b (w_lane_b)
  );

  always_ff @(posedge clk) begin
    if (w_ld_fire) begin
      r_a_rows[w_widx] <= ld_row_a;
      r_b_cols[w_widx] <= ld_col_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= SEQ_IDLE;
      r_beat      <= '0;
      r_t         <= '0;
      r_dcnt      <= '0;
      r_sa_clear  <= 1'b0;
      r_sa_in_a   <= '0;
      r_sa_in_b   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_abort) begin
      r_state     <= SEQ_IDLE;
      r_beat      <= '0;
      r_t         <= '0;
      r_dcnt      <= '0;
      r_sa_clear  <= 1'b0;
      r_sa_in_a   <= '0;
      r_sa_in_b   <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      unique case (r_state)
        SEQ_IDLE: begin
          if (ld_valid) begin
            r_beat  <= BW'(1);
            r_state <= SEQ_LOAD;
          end
        end
        SEQ_LOAD: begin
          if (ld_valid) begin
            if (r_beat == B_LAST) begin
              r_beat     <= '0;
              r_sa_clear <= 1'b1;
              r_state    <= SEQ_CLEAR;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        SEQ_CLEAR: begin
          r_sa_clear <= 1'b0;
          r_t        <= '0;
          r_sa_in_a  <= w_lane_a;
          r_sa_in_b  <= w_lane_b;
          r_state    <= SEQ_FEED;
        end
        SEQ_FEED: begin
          if (r_t == T_LAST) begin
            r_t       <= '0;
            r_dcnt    <= '0;
            r_sa_in_a <= '0;
            r_sa_in_b <= '0;
            r_state   <= SEQ_DRAIN;
          end else begin
            r_t       <= w_t_nxt;
            r_sa_in_a <= w_lane_a;
            r_sa_in_b <= w_lane_b;
          end
        end
        SEQ_DRAIN: begin
          if (r_dcnt == D_LAST) begin
            r_dcnt      <= '0;
            r_rsp_data  <= sa_result;
            r_rsp_valid <= 1'b1;
            r_state     <= SEQ_DONE;
          end else begin
            r_dcnt <= r_dcnt + TW'(1);
          end
        end
        SEQ_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= SEQ_IDLE;
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_sau_sequencer.sv
// Directed bench for vx_sau_sequencer driving a behavioural
// 3x3 output-stationary systolic array model.
module tb_vx_sau_sequencer;

  typedef logic [8:0][7:0]  mat_t;
  typedef logic [8:0][31:0] res_t;
  typedef logic [2:0][7:0]  lane_t;

  typedef struct {
    mat_t a;
    mat_t b;
    res_t c;
    bit   skew;
  } op_vec_t;

  typedef struct {
    lane_t a;
    lane_t b;
  } skew_vec_t;

  logic clk = 1'b0;
  logic reset;
  logic ld_valid;
  logic ld_ready;
  lane_t ld_row_a;
  lane_t ld_col_b;
  logic abort;
  logic busy;
  logic sa_clear;
  lane_t sa_in_a;
  lane_t sa_in_b;
  logic [2:0][2:0][31:0] sa_result;
  logic rsp_valid;
  logic rsp_ready;
  logic [2:0][2:0][31:0] rsp_data;

  int n_vec = 0;
  int n_err = 0;
  op_vec_t   ops [5];
  skew_vec_t skt [5];

  always #5 clk = ~clk;

  vx_sau_sequencer #(
    .MATRIX_SIZE (3),
    .DATA_SIZE   (8),
    .ACC_SIZE    (32),
    .SA_LATENCY  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_row_a  (ld_row_a),
    .ld_col_b  (ld_col_b),
    .abort     (abort),
    .busy      (busy),
    .sa_clear  (sa_clear),
    .sa_in_a   (sa_in_a),
    .sa_in_b   (sa_in_b),
    .sa_result (sa_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  // Array model: PE(i,j) sees row lane i delayed j and column lane j
  // delayed i; accumulators form the single register stage.
  logic [1:0][7:0] dla [3];
  logic [1:0][7:0] dlb [3];
  lane_t cura [3];
  lane_t curb [3];
  logic [31:0] acc [3][3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cura[i] = {dla[i], sa_in_a[i]};
      curb[i] = {dlb[i], sa_in_b[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sa_result[i][j] = acc[i][j];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      dla[i] <= cura[i][1:0];
      dlb[i] <= curb[i][1:0];
      for (int j = 0; j < 3; j++) begin
        if (sa_clear)
          acc[i][j] <= 32'd0;
        else
          acc[i][j] <= acc[i][j] +
            32'(cura[i][j]) * 32'(curb[j][i]);
      end
    end
  end

  function automatic mat_t mk(input int v[9]);
    mat_t m;
    for (int i = 0; i < 9; i++) m[i] = 8'(v[i]);
    return m;
  endfunction

  function automatic res_t rk(input int v[9]);
    res_t m;
    for (int i = 0; i < 9; i++) m[i] = 32'(v[i]);
    return m;
  endfunction

  function automatic lane_t ln(input int x0, input int x1, input int x2);
    return {8'(x2), 8'(x1), 8'(x0)};
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [287:0] act,
                      input logic [287:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input mat_t a, input mat_t b, input bit bub);
    for (int r = 0; r < 3; r++) begin
      if (bub && r > 0) begin
        ld_valid = 1'b0;
        cyc();
      end
      ld_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        ld_row_a[c] = a[r*3+c];
        ld_col_b[c] = b[c*3+r];
      end
      cyc();
    end
    ld_valid = 1'b0;
  endtask

  // Entered one cycle after the last beat edge (the CLEAR cycle).
  task automatic wait_rsp(input bit sk_en, output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      if (lat == 0) chk1("clear_pulse", sa_clear, 1'b1);
      if (sk_en && lat == 1) chk1("clear_width", sa_clear, 1'b0);
      if (sk_en && lat >= 1 && lat <= 5) begin
        chkw("skew_a", 288'(sa_in_a), 288'(skt[lat-1].a));
        chkw("skew_b", 288'(sa_in_b), 288'(skt[lat-1].b));
      end
      if (sk_en && lat == 6)
        chkw("drain_zero", 288'({sa_in_a, sa_in_b}), 288'(0));
      cyc();
      lat++;
    end
  endtask

  task automatic finish_rsp(input res_t c);
    chkw("rsp_data", 288'(rsp_data), 288'(c));
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk1("post_busy", busy, 1'b0);
    chk1("post_rsp_valid", rsp_valid, 1'b0);
  endtask

  task automatic full_op(input op_vec_t v, input bit bub);
    int lat;
    load(v.a, v.b, bub);
    wait_rsp(v.skew, lat);
    chkw("latency", 288'(lat), 288'(9));
    finish_rsp(v.c);
  endtask

  initial begin
    int lat;
    bit ok;
    bit seen;

    ops[0] = '{mk('{1,0,0,0,1,0,0,0,1}), mk('{1,2,3,4,5,6,7,8,9}),
               rk('{1,2,3,4,5,6,7,8,9}), 1'b0};
    ops[1] = '{mk('{1,2,3,4,5,6,7,8,9}), mk('{1,0,0,0,1,0,0,0,1}),
               rk('{1,2,3,4,5,6,7,8,9}), 1'b0};
    ops[2] = '{mk('{2,0,0,0,2,0,0,0,2}), mk('{1,2,3,4,5,6,7,8,9}),
               rk('{2,4,6,8,10,12,14,16,18}), 1'b0};
    ops[3] = '{mk('{1,2,3,4,5,6,7,8,9}), mk('{1,2,3,4,5,6,7,8,9}),
               rk('{30,36,42,66,81,96,102,126,150}), 1'b1};
    ops[4] = '{mk('{255,255,255,255,255,255,255,255,255}),
               mk('{255,255,255,255,255,255,255,255,255}),
               rk('{195075,195075,195075,195075,195075,
                    195075,195075,195075,195075}), 1'b0};
    skt[0] = '{ln(1,0,0), ln(1,0,0)};
    skt[1] = '{ln(2,4,0), ln(4,2,0)};
    skt[2] = '{ln(3,5,7), ln(7,5,3)};
    skt[3] = '{ln(0,6,8), ln(0,8,6)};
    skt[4] = '{ln(0,0,9), ln(0,0,9)};

    reset     = 1'b0;
    ld_valid  = 1'b0;
    ld_row_a  = '0;
    ld_col_b  = '0;
    abort     = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) cyc();
    chk1("rst_ld_ready", ld_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_sa_clear", sa_clear, 1'b0);
    chkw("rst_sa_in", 288'({sa_in_a, sa_in_b}), 288'(0));
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chkw("rst_rsp_data", 288'(rsp_data), 288'(0));
    reset = 1'b1;
    cyc();

    for (int v = 0; v < 5; v++) full_op(ops[v], 1'b0);

    // Bubbled load followed by held-off response.
    load(ops[3].a, ops[3].b, 1'b1);
    chk1("bub_ld_ready", ld_ready, 1'b0);
    wait_rsp(1'b0, lat);
    chkw("bub_latency", 288'(lat), 288'(9));
    ok = 1'b1;
    repeat (5) begin
      if (rsp_data !== ops[3].c || ld_ready !== 1'b0 || rsp_valid !== 1'b1)
        ok = 1'b0;
      cyc();
    end
    chk1("bp_hold", ok, 1'b1);
    finish_rsp(ops[3].c);

    // Abort at FEED t=2.
    load(ops[0].a, ops[0].b, 1'b0);
    repeat (3) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ld_ready", ld_ready, 1'b1);
    seen = 1'b0;
    repeat (15) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      cyc();
    end
    chk1("abort_no_rsp", seen, 1'b0);
    full_op(ops[3], 1'b0);

    // Abort together with rsp_ready in DONE.
    load(ops[2].a, ops[2].b, 1'b0);
    wait_rsp(1'b0, lat);
    chk1("done_valid", rsp_valid, 1'b1);
    abort     = 1'b1;
    rsp_ready = 1'b1;
    cyc();
    abort     = 1'b0;
    rsp_ready = 1'b0;
    chk1("abort_done_busy", busy, 1'b0);
    chk1("abort_done_valid", rsp_valid, 1'b0);

    // Reset pulse in the middle of DRAIN.
    load(ops[4].a, ops[4].b, 1'b0);
    repeat (7) cyc();
    chk1("pre_rst_busy", busy, 1'b1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk1("mrst_ld_ready", ld_ready, 1'b1);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_sa_clear", sa_clear, 1'b0);
    chkw("mrst_sa_in", 288'({sa_in_a, sa_in_b}), 288'(0));
    chk1("mrst_rsp_valid", rsp_valid, 1'b0);
    chkw("mrst_rsp_data", 288'(rsp_data), 288'(0));
    full_op(ops[1], 1'b0);

    // Load presented during the response handshake is not taken.
    load(ops[0].a, ops[0].b, 1'b0);
    wait_rsp(1'b0, lat);
    chkw("b2b_data", 288'(rsp_data), 288'(ops[0].c));
    rsp_ready = 1'b1;
    ld_valid  = 1'b1;
    ld_row_a  = {8'hEE, 8'hEE, 8'hEE};
    ld_col_b  = {8'hEE, 8'hEE, 8'hEE};
    cyc();
    rsp_ready = 1'b0;
    chk1("b2b_idle_busy", busy, 1'b0);
    chk1("b2b_idle_ready", ld_ready, 1'b1);
    full_op(ops[3], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vx_sau_sequencer.md
# vx_sau_sequencer

Control sequencer for the SAU systolic array: accepts operand matrices A and B from the issue side over a valid/ready load channel, buffers them, clears the array, streams skewed diagonal wavefronts into the array's row and column inputs, waits for the pipeline to drain, then captures and returns the result tile over a valid/ready response channel. It sits between the SAU request path and `VX_systolic_array`, and replaces ad-hoc cycle counting in the unit wrapper.

## Interface
- `MATRIX_SIZE`, 3: N, array dimension (N ≥ 2).
- `DATA_SIZE`, 8: operand element width.
- `ACC_SIZE`, 32: result element width, as produced by the array.
- `SA_LATENCY`, 1: register stages from `sa_in_*` to the first PE.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-low.
- `ld_valid`, in, 1: load beat valid.
- `ld_ready`, out, 1: load beat accepted when high together with `ld_valid`.
- `ld_row_a`, in, [N][DATA_SIZE]: row r of A, where r is the beat index.
- `ld_col_b`, in, [N][DATA_SIZE]: column r of B.
- `abort`, in, 1: flush the current operation.
- `busy`, out, 1: high in every state except IDLE.
- `sa_clear`, out, 1: one-cycle accumulator clear to the array.
- `sa_in_a`, out, [N][DATA_SIZE]: row-edge inputs to the array.
- `sa_in_b`, out, [N][DATA_SIZE]: column-edge inputs to the array.
- `sa_result`, in, [N][N][ACC_SIZE]: array accumulators.
- `rsp_valid`, out, 1: result available.
- `rsp_ready`, in, 1: consumer accepts the result.
- `rsp_data`, out, [N][N][ACC_SIZE]: captured result.

## Operation
States: IDLE, LOAD, CLEAR, FEED, DRAIN, DONE.
- **IDLE**: `ld_ready=1`. An accepted beat writes row 0 of `A_buf` and column 0 of `B_buf`, sets `beat=1`, and moves to LOAD.
- **LOAD**: `ld_ready=1`. Each accepted beat writes index `beat`, then `beat++`. Acceptance with `beat==N-1` moves to CLEAR. Bubbles (`ld_valid=0`) are allowed and hold the state.
- **CLEAR**: one cycle with `sa_clear=1`, then FEED with `t=0`.
- **FEED**: lasts 2N-1 cycles, t = 0..2N-2. For each lane k, with `d = t-k`:
  - `sa_in_a[k] = A_buf[k][d]` and `sa_in_b[k] = B_buf[d][k]` when 0 ≤ d < N.
  - Otherwise both are 0.
  - After t = 2N-2, go to DRAIN.
- **DRAIN**: N-1+SA_LATENCY cycles with `sa_in_*` held at 0. On the last cycle, `rsp_data <= sa_result`. Then go to DONE.
- **DONE**: `rsp_valid=1` and `rsp_data` is held stable. On `rsp_valid && rsp_ready`, go to IDLE.
- `ld_ready=0` in CLEAR, FEED, DRAIN and DONE. No new load overlaps an operation in flight.
- **abort**: in any non-IDLE state, the next state is IDLE and `beat` and `t` reset. `rsp_valid` drops the next cycle. Buffers are not cleared. Abort has priority over `ld_valid` acceptance and over `rsp_ready` in the same cycle.
- Counters: `beat` is $clog2(N) bits. `t` and the drain counter are $clog2(2N) bits. No wrap is reachable.

## Timing
- **Reset** (`reset=0` at a clock edge): state IDLE, `ld_ready=1`, `busy=0`, `sa_clear=0`, `sa_in_a=0`, `sa_in_b=0`, `rsp_valid=0`, `rsp_data=0`. Reset mid-operation behaves like abort and also zeroes `rsp_data`.
- All outputs are registered, except `ld_ready` and `busy`, which decode directly from state.
- **Latency**, counted from the edge accepting the last load beat to `rsp_valid` rising:
  - 1 (CLEAR) + (2N-1) (FEED) + (N-1+SA_LATENCY) (DRAIN) = 3N-1+SA_LATENCY cycles.
  - For N=3 and SA_LATENCY=1: 9 cycles.
- **Throughput**: one operation per N + 3N-1+SA_LATENCY + 1 cycles minimum, with `rsp_ready` held high.
- The `sa_clear` pulse occurs exactly one cycle before the t=0 wavefront.

## Structure
- The shared SAU package holds:
  - the state enum `sau_seq_state_t`;
  - helper functions for the feed and drain cycle counts;
  - the element and accumulator typedefs, shared with `VX_systolic_array`.
- One sub-module, `VX_sau_skew`, is natural: combinational, taking `A_buf`, `B_buf` and `t` and producing the skewed lane vectors. The sequencer registers its outputs.

## Test plan
- **Skew pattern** (N=3): A rows {1,2,3}, {4,5,6}, {7,8,9} → `sa_in_a` over FEED cycles 0–4 is {1,0,0}, {2,4,0}, {3,5,7}, {0,6,8}, {0,0,9}. B columns give the mirrored pattern on `sa_in_b`.
- **Identity multiply**: A=I, B=1..9, using a real `VX_systolic_array`.
  - `rsp_data` equals B.
  - `rsp_valid` rises exactly 9 cycles after the third load beat.
- **Load bubbles and backpressure**:
  - `ld_valid` toggled 1,0,1,0,1 → exactly 3 beats accepted.
  - `rsp_ready` held low 5 cycles → `rsp_data` is stable and `ld_ready` stays 0 until the handshake.
- **Abort**:
  - Abort at FEED t=2 → IDLE on the next cycle, `rsp_valid` never asserts, and a following full operation returns the correct result.
  - Abort coincident with `rsp_ready` in DONE → IDLE.
- **Reset mid-DRAIN** (`reset=0` for one cycle) → all outputs take their reset values on the next cycle; a following operation is correct.
- **Back-to-back**: `ld_valid` asserted in the same cycle as the `rsp` handshake is not accepted. It is accepted on the next cycle in IDLE.
